// File: rtl/tile_plotter_pkg.sv
// Shared definitions for the tile plotter: block type codes, pixel colours, tile geometry and
// the plotter state encoding. The arena RAM initialiser and game datapath use the same codes.
package tile_plotter_pkg;

  // Tile edge is 1 << TileBits pixels.
  localparam int unsigned TileBits = 3;
  localparam int unsigned TileW    = 1 << TileBits;

  // Block type codes carried on tile_val.
  localparam logic [2:0] BlkTile   = 3'd0;
  localparam logic [2:0] BlkPlayer = 3'd1;
  localparam logic [2:0] BlkWall   = 3'd2;
  localparam logic [2:0] BlkBlock  = 3'd3;
  localparam logic [2:0] BlkBomb   = 3'd4;

  // 3-bit RGB colours, bit 2 = red, bit 1 = green, bit 0 = blue.
  localparam logic [2:0] ColBlack   = 3'b000;
  localparam logic [2:0] ColBlue    = 3'b001;
  localparam logic [2:0] ColGreen   = 3'b010;
  localparam logic [2:0] ColRed     = 3'b100;
  localparam logic [2:0] ColMagenta = 3'b101;
  localparam logic [2:0] ColYellow  = 3'b110;
  localparam logic [2:0] ColWhite   = 3'b111;

  // Colour used for any block code outside the defined range.
  localparam logic [2:0] ColInvalid = ColMagenta;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } plot_state_e;

endpackage

// File: rtl/tile_colour.sv
// Combinational pixel colour lookup: block type plus in-tile pixel position gives RGB colour.
// A pixel is on the border when either coordinate sits on the first or last row/column.
module tile_colour
  import tile_plotter_pkg::*;
#(
  parameter int unsigned TILE_BITS = TileBits
) (
  input  logic [2:0]           tile_val_i,
  input  logic [TILE_BITS-1:0] px_i,
  input  logic [TILE_BITS-1:0] py_i,
  output logic [2:0]           colour_o
);

  logic border;

  // Border detection on the outermost ring of the tile.
  always_comb begin
    border = (px_i == '0) || (px_i == '1) || (py_i == '0) || (py_i == '1);
  end

  // Colour selection per block type; codes 5-7 fall through to the invalid colour.
  always_comb begin
    colour_o = ColInvalid;
    case (tile_val_i)
      BlkTile:   colour_o = ColGreen;
      BlkPlayer: colour_o = border ? ColGreen : ColBlue;
      BlkWall:   colour_o = ColWhite;
      BlkBlock:  colour_o = border ? ColBlack : ColYellow;
      BlkBomb:   colour_o = border ? ColGreen : ColRed;
      default:   colour_o = ColInvalid;
    endcase
  end

endmodule

// File: rtl/tile_plotter.sv
// Expands one tile request into TILE_W x TILE_W raster-order pixel writes for the VGA adapter.
// A single pending slot holds one request that arrives while a tile is being drawn; a further
// request in that window is dropped and flagged on the sticky overflow output.
module tile_plotter
  import tile_plotter_pkg::*;
#(
  parameter int unsigned TILE_BITS = TileBits,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plot,
  input  logic [COORD_W-1:0] tile_x,
  input  logic [COORD_W-1:0] tile_y,
  input  logic [2:0]         tile_val,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  plot_state_e state_q;

  // Position of the pixel currently presented on the vga_* outputs.
  logic [TILE_BITS-1:0] px_q, py_q;

  // Tile being drawn.
  logic [COORD_W-1:0] act_x_q, act_y_q;
  logic [2:0]         act_val_q;

  // One-deep holding slot for a request that arrives mid-draw.
  logic               pend_valid_q;
  logic [COORD_W-1:0] pend_x_q, pend_y_q;
  logic [2:0]         pend_val_q;

  logic               busy_q, done_q, overflow_q, vga_plot_q;
  logic [X_W-1:0]     vga_x_q;
  logic [Y_W-1:0]     vga_y_q;
  logic [2:0]         vga_colour_q;

  // Next raster position and the pixel to present on the coming edge.
  logic                 last_pix;
  logic [TILE_BITS-1:0] px_nxt, py_nxt;
  logic [COORD_W-1:0]   src_x, src_y;
  logic [2:0]           src_val;
  logic [TILE_BITS-1:0] src_px, src_py;
  logic [2:0]           src_colour;

  // Raster stepping: px wraps at the tile edge and carries into py.
  always_comb begin
    last_pix = (px_q == '1) && (py_q == '1);
    px_nxt   = px_q + TILE_BITS'(1);
    py_nxt   = (px_q == '1) ? py_q + TILE_BITS'(1) : py_q;
  end

  // Select the source of the next pixel: the active tile while drawing, otherwise the first
  // pixel of whichever request starts next (pending slot has priority over a fresh plot).
  always_comb begin
    src_x   = act_x_q;
    src_y   = act_y_q;
    src_val = act_val_q;
    src_px  = px_nxt;
    src_py  = py_nxt;
    if (state_q != StDraw) begin
      src_px = '0;
      src_py = '0;
      if ((state_q == StDone) && pend_valid_q) begin
        src_x   = pend_x_q;
        src_y   = pend_y_q;
        src_val = pend_val_q;
      end else begin
        src_x   = tile_x;
        src_y   = tile_y;
        src_val = tile_val;
      end
    end
  end

  tile_colour #(
    .TILE_BITS (TILE_BITS)
  ) u_tile_colour (
    .tile_val_i (src_val),
    .px_i       (src_px),
    .py_i       (src_py),
    .colour_o   (src_colour)
  );

  // Plotter FSM with registered outputs; every pixel write is registered from the src_* view.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      px_q         <= '0;
      py_q         <= '0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_val_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_val_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (plot) begin
            act_x_q      <= src_x;
            act_y_q      <= src_y;
            act_val_q    <= src_val;
            px_q         <= '0;
            py_q         <= '0;
            vga_plot_q   <= 1'b1;
            vga_x_q      <= X_W'({src_x, src_px});
            vga_y_q      <= Y_W'({src_y, src_py});
            vga_colour_q <= src_colour;
            busy_q       <= 1'b1;
            state_q      <= StDraw;
          end
        end

        StDraw: begin
          if (plot) begin
            if (!pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_x_q     <= tile_x;
              pend_y_q     <= tile_y;
              pend_val_q   <= tile_val;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (last_pix) begin
            vga_plot_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            px_q         <= px_nxt;
            py_q         <= py_nxt;
            vga_x_q      <= X_W'({src_x, src_px});
            vga_y_q      <= Y_W'({src_y, src_py});
            vga_colour_q <= src_colour;
          end
        end

        StDone: begin
          if (pend_valid_q || plot) begin
            // A plot here refills the slot only if the slot is being drained this cycle.
            if (pend_valid_q) begin
              pend_valid_q <= plot;
              if (plot) begin
                pend_x_q   <= tile_x;
                pend_y_q   <= tile_y;
                pend_val_q <= tile_val;
              end
            end
            act_x_q      <= src_x;
            act_y_q      <= src_y;
            act_val_q    <= src_val;
            px_q         <= '0;
            py_q         <= '0;
            vga_plot_q   <= 1'b1;
            vga_x_q      <= X_W'({src_x, src_px});
            vga_y_q      <= Y_W'({src_y, src_py});
            vga_colour_q <= src_colour;
            state_q      <= StDraw;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          busy_q     <= 1'b0;
          vga_plot_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign vga_plot   = vga_plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule
